// File: rtl/spw_xbar_switch.sv
// SpaceWire router crossbar: per-input packet FSMs feed per-output round-robin
// arbiters that stay locked to one packet until its EOP/EEP has been handed over.
module spw_xbar_switch #(
  parameter int BW      = 9,
  parameter int PORTNUM = 16,
  parameter int AW      = 5
) (
  input  logic                  gclk,
  input  logic                  reset,
  input  logic [PORTNUM*BW-1:0] in_data_i,
  input  logic [PORTNUM-1:0]    in_valid_i,
  output logic [PORTNUM-1:0]    in_ready_o,
  input  logic [PORTNUM*AW-1:0] in_dest_i,
  input  logic [PORTNUM-1:0]    port_en_i,
  output logic [PORTNUM*BW-1:0] out_data_o,
  output logic [PORTNUM-1:0]    out_valid_o,
  input  logic [PORTNUM-1:0]    out_ready_i,
  output logic [PORTNUM-1:0]    out_busy_o,
  output logic [PORTNUM-1:0]    drop_o,
  output logic [PORTNUM*2-1:0]  in_state_o
);
  localparam int PW = $clog2(PORTNUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DROP = 2'd3
  } in_state_e;

  // Handshake: a character moves on a port in any cycle where valid & ready are
  // both high at the rising edge; valid never waits on ready combinationally.
  in_state_e          state_q [PORTNUM];
  in_state_e          state_d [PORTNUM];
  logic [AW-1:0]      dest_q  [PORTNUM];
  logic [AW-1:0]      dest_d  [PORTNUM];
  logic [PW-1:0]      owner_q [PORTNUM];
  logic [PW-1:0]      owner_d [PORTNUM];
  logic [PW-1:0]      rr_q    [PORTNUM];
  logic [PW-1:0]      rr_d    [PORTNUM];
  logic [PORTNUM-1:0] drop_q, drop_d;
  logic [PORTNUM-1:0] locked_q, locked_d;
  logic [PORTNUM-1:0] req, grant, rel;

  function automatic logic is_eop(input logic [BW-1:0] c);
    return c[BW-1] && ((c[7:0] & 8'hFE) == 8'h00);
  endfunction

  // Out-of-range indices select nothing, so an address >= PORTNUM reads as 0.
  function automatic logic sel_bit(input logic [PORTNUM-1:0] vec,
                                   input logic [AW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < PORTNUM; i++) begin
      if (int'(idx) == i) r = vec[i];
    end
    return r;
  endfunction

  always_comb begin
    for (int p = 0; p < PORTNUM; p++) begin
      req[p] = (state_q[p] == S_REQ);
      in_state_o[p*2 +: 2] = state_q[p];
    end
  end

  // Output datapath and end-of-packet release detection.
  always_comb begin
    out_data_o  = '0;
    out_valid_o = '0;
    rel         = '0;
    for (int o = 0; o < PORTNUM; o++) begin
      if (locked_q[o]) begin
        out_data_o[o*BW +: BW] = in_data_i[int'(owner_q[o])*BW +: BW];
        out_valid_o[o]         = in_valid_i[owner_q[o]];
        rel[o] = in_valid_i[owner_q[o]] && out_ready_i[o] &&
                 is_eop(in_data_i[int'(owner_q[o])*BW +: BW]);
      end
    end
  end

  // Per-output arbiter: a free output grants the first requester at or after rr.
  always_comb begin : arb_comb
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    grant = '0;
    for (int o = 0; o < PORTNUM; o++) begin
      locked_d[o] = locked_q[o];
      owner_d[o]  = owner_q[o];
      rr_d[o]     = rr_q[o];
      if (!locked_q[o]) begin
        found = 1'b0;
        for (int k = 0; k < PORTNUM; k++) begin
          idx = (int'(rr_q[o]) + k) % PORTNUM;
          if (!found && req[idx] && (int'(dest_q[idx]) == o)) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            locked_d[o] = 1'b1;
            owner_d[o]  = PW'(idx);
            rr_d[o]     = PW'((idx + 1) % PORTNUM);
          end
        end
      end else if (rel[o]) begin
        locked_d[o] = 1'b0;
      end
    end
  end

  // Per-input packet FSM.
  always_comb begin
    in_ready_o = '0;
    drop_d     = '0;
    for (int p = 0; p < PORTNUM; p++) begin
      state_d[p] = state_q[p];
      dest_d[p]  = dest_q[p];
      case (state_q[p])
        S_IDLE: begin
          if (in_valid_i[p]) begin
            dest_d[p] = in_dest_i[p*AW +: AW];
            if (!sel_bit(port_en_i, in_dest_i[p*AW +: AW])) begin
              state_d[p] = S_DROP;
              drop_d[p]  = 1'b1;
            end else begin
              state_d[p] = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (grant[p]) state_d[p] = S_XFER;
        end
        S_XFER: begin
          in_ready_o[p] = sel_bit(out_ready_i, dest_q[p]);
          if (in_valid_i[p] && in_ready_o[p] && is_eop(in_data_i[p*BW +: BW]))
            state_d[p] = S_IDLE;
        end
        S_DROP: begin
          in_ready_o[p] = 1'b1;
          if (in_valid_i[p] && is_eop(in_data_i[p*BW +: BW]))
            state_d[p] = S_IDLE;
        end
        default: state_d[p] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PORTNUM; i++) begin
        state_q[i] <= S_IDLE;
        dest_q[i]  <= '0;
        owner_q[i] <= '0;
        rr_q[i]    <= '0;
      end
      drop_q   <= '0;
      locked_q <= '0;
    end else begin
      for (int i = 0; i < PORTNUM; i++) begin
        state_q[i] <= state_d[i];
        dest_q[i]  <= dest_d[i];
        owner_q[i] <= owner_d[i];
        rr_q[i]    <= rr_d[i];
      end
      drop_q   <= drop_d;
      locked_q <= locked_d;
    end
  end

  assign out_busy_o = locked_q;
  assign drop_o     = drop_q;

endmodule
